// File: rtl/layer_seq.sv
// Layer scheduler: walks 8-word descriptors in config ROM, loads the shared geometry
// registers, launches the conv or maxp engine and flips the ping-pong buffer on completion.
module layer_seq #(
   parameter int DATA_SIZE     = 32,
   parameter int CFG_ADDR_BITS = 8,
   parameter int MAX_LAYERS    = 16,
   parameter int LAYER_BITS    = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [CFG_ADDR_BITS-1:0] base_addr,
   output logic [CFG_ADDR_BITS-1:0] cfg_ra,
   input  logic [DATA_SIZE-1:0]     cfg_rd,
   output logic [DATA_SIZE-1:0]     R,
   output logic [DATA_SIZE-1:0]     C,
   output logic [DATA_SIZE-1:0]     M,
   output logic [DATA_SIZE-1:0]     nIR,
   output logic [DATA_SIZE-1:0]     nIC,
   output logic [DATA_SIZE-1:0]     nP,
   output logic [DATA_SIZE-1:0]     MP,
   output logic                     conv_en,
   input  logic                     conv_done,
   output logic                     maxp_en,
   input  logic                     maxp_done,
   output logic                     buf_sel,
   output logic [LAYER_BITS-1:0]    layer_cnt,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_LAUNCH,
      S_WAIT,
      S_FIN
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [2:0]               k;
   logic [CFG_ADDR_BITS-1:0] ptr;
   logic                     cap_pending;
   logic [2:0]               cap_k;
   logic [DATA_SIZE-1:0]     type_q;
   logic                     is_conv;
   logic                     is_maxp;
   logic                     eng_done;
   logic                     at_limit;
   logic                     decode_err;

   assign is_conv  = (type_q == DATA_SIZE'(1));
   assign is_maxp  = (type_q == DATA_SIZE'(2));
   assign at_limit = (layer_cnt == LAYER_BITS'(MAX_LAYERS));
   // Only the engine that was launched can end the wait; the other done is noise.
   assign eng_done = (is_conv && conv_done) || (is_maxp && maxp_done);

   assign decode_err = (state == S_DECODE) &&
                       ((is_conv || is_maxp) ? at_limit : (type_q != '0));

   assign cfg_ra  = (state == S_FETCH) ? (ptr + CFG_ADDR_BITS'(k)) : '0;
   assign conv_en = (state == S_LAUNCH) && is_conv;
   assign maxp_en = (state == S_LAUNCH) && is_maxp;
   assign busy    = (state != S_IDLE);
   assign done    = (state == S_FIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_FETCH;
         S_FETCH:  if (k == 3'd7) state_nxt = S_DECODE;
         S_DECODE: begin
            if ((is_conv || is_maxp) && !at_limit) state_nxt = S_LAUNCH;
            else                                   state_nxt = S_FIN;
         end
         S_LAUNCH: state_nxt = S_WAIT;
         S_WAIT:   if (eng_done) state_nxt = S_FETCH;
         S_FIN:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // ROM data lags the address by a cycle, so each word lands one cycle after its
   // fetch slot; the last word is therefore written while DECODE is active.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_pending <= 1'b0;
         cap_k       <= '0;
         type_q      <= '0;
         R           <= '0;
         C           <= '0;
         M           <= '0;
         nIR         <= '0;
         nIC         <= '0;
         nP          <= '0;
         MP          <= '0;
      end else begin
         cap_pending <= (state == S_FETCH);
         cap_k       <= k;
         if (cap_pending) begin
            case (cap_k)
               3'd0: type_q <= cfg_rd;
               3'd1: R      <= cfg_rd;
               3'd2: C      <= cfg_rd;
               3'd3: M      <= cfg_rd;
               3'd4: nIR    <= cfg_rd;
               3'd5: nIC    <= cfg_rd;
               3'd6: nP     <= cfg_rd;
               default: MP  <= cfg_rd;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k         <= '0;
         ptr       <= '0;
         buf_sel   <= 1'b0;
         layer_cnt <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  ptr       <= base_addr;
                  layer_cnt <= '0;
                  err       <= 1'b0;
                  buf_sel   <= 1'b0;
                  k         <= '0;
               end
            end
            S_FETCH:  k <= k + 3'd1;
            S_DECODE: if (decode_err) err <= 1'b1;
            S_WAIT: begin
               if (eng_done) begin
                  buf_sel   <= ~buf_sel;
                  layer_cnt <= layer_cnt + LAYER_BITS'(1);
                  ptr       <= ptr + CFG_ADDR_BITS'(8);
                  k         <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_seq.sv
// Self-checking bench for layer_seq: ROM and engine responders plus a descriptor-walk
// reference model that predicts launches, geometry, buffer select and error outcome.
module tb_layer_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  base_addr;
   logic [7:0]  cfg_ra;
   logic [31:0] cfg_rd;
   logic [31:0] R, C, M, nIR, nIC, nP, MP;
   logic        conv_en, conv_done, maxp_en, maxp_done;
   logic        buf_sel, busy, done, err;
   logic [4:0]  layer_cnt;

   logic        conv_auto, conv_man, maxp_auto, maxp_man;
   assign conv_done = conv_auto | conv_man;
   assign maxp_done = maxp_auto | maxp_man;

   layer_seq dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .cfg_ra(cfg_ra), .cfg_rd(cfg_rd),
      .R(R), .C(C), .M(M), .nIR(nIR), .nIC(nIC), .nP(nP), .MP(MP),
      .conv_en(conv_en), .conv_done(conv_done),
      .maxp_en(maxp_en), .maxp_done(maxp_done),
      .buf_sel(buf_sel), .layer_cnt(layer_cnt),
      .busy(busy), .done(done), .err(err)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0]  rom [256];
   int           conv_lat = 50;
   int           maxp_lat = 30;
   bit           auto_resp = 1'b1;
   int           done_cnt = 0;
   logic [31:0]  launch_kind [$];
   logic [223:0] launch_geo [$];
   logic         launch_bs [$];
   logic [31:0]  exp_kind [$];
   logic [223:0] exp_geo [$];
   int           exp_cnt;
   logic         exp_err;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cfg_rd <= rom[cfg_ra];

   // Engine responders: done arrives a programmable number of cycles after en.
   initial begin
      int cc, mc;
      cc = 0;
      mc = 0;
      forever begin
         @(negedge clk);
         conv_auto = 1'b0;
         maxp_auto = 1'b0;
         if (rst) begin
            cc = 0;
            mc = 0;
         end
         if (cc > 0) begin
            cc--;
            if (cc == 0) conv_auto = 1'b1;
         end
         if (mc > 0) begin
            mc--;
            if (mc == 0) maxp_auto = 1'b1;
         end
         if (auto_resp && conv_en) cc = conv_lat;
         if (auto_resp && maxp_en) mc = maxp_lat;
      end
   end

   // Launch and done monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (conv_en) begin
            launch_kind.push_back(32'd1);
            launch_geo.push_back({R, C, M, nIR, nIC, nP, MP});
            launch_bs.push_back(buf_sel);
         end
         if (maxp_en) begin
            launch_kind.push_back(32'd2);
            launch_geo.push_back({R, C, M, nIR, nIC, nP, MP});
            launch_bs.push_back(buf_sel);
         end
         if (done) done_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_desc(input logic [7:0] a, input logic [31:0] t,
                             input logic [31:0] r, input logic [31:0] c, input logic [31:0] m,
                             input logic [31:0] nir, input logic [31:0] nic,
                             input logic [31:0] np, input logic [31:0] mp);
      rom[a]        = t;
      rom[a + 8'd1] = r;
      rom[a + 8'd2] = c;
      rom[a + 8'd3] = m;
      rom[a + 8'd4] = nir;
      rom[a + 8'd5] = nic;
      rom[a + 8'd6] = np;
      rom[a + 8'd7] = mp;
   endtask

   // Walk the descriptor list the way the scheduler is meant to interpret it.
   task automatic build_expected(input logic [7:0] base);
      logic [7:0]  p;
      logic [31:0] t;
      bit          stop;
      p = base;
      exp_cnt = 0;
      exp_err = 1'b0;
      exp_kind.delete();
      exp_geo.delete();
      stop = 1'b0;
      for (int guard = 0; guard < 64 && !stop; guard++) begin
         t = rom[p];
         if (t == 32'd0) begin
            stop = 1'b1;
         end else if (t == 32'd1 || t == 32'd2) begin
            if (exp_cnt == 16) begin
               exp_err = 1'b1;
               stop = 1'b1;
            end else begin
               exp_kind.push_back(t);
               exp_geo.push_back({rom[p + 8'd1], rom[p + 8'd2], rom[p + 8'd3], rom[p + 8'd4],
                                  rom[p + 8'd5], rom[p + 8'd6], rom[p + 8'd7]});
               exp_cnt++;
               p = p + 8'd8;
            end
         end else begin
            exp_err = 1'b1;
            stop = 1'b1;
         end
      end
   endtask

   task automatic wait_done(input int d0, input string tag);
      for (int i = 0; i < 3000 && done_cnt == d0; i++) tick(1);
      check({tag, "/done_seen"}, 256'(done_cnt > d0), 256'(1));
      tick(3);
   endtask

   task automatic compare_run(input int d0, input string tag);
      int n;
      check({tag, "/n_launch"}, 256'(launch_kind.size()), 256'(exp_kind.size()));
      n = (launch_kind.size() < exp_kind.size()) ? launch_kind.size() : exp_kind.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "/kind"}, 256'(launch_kind[i]), 256'(exp_kind[i]));
         check({tag, "/geo"}, 256'(launch_geo[i]), 256'(exp_geo[i]));
         check({tag, "/bufsel_at_en"}, 256'(launch_bs[i]), 256'(i % 2));
      end
      check({tag, "/layer_cnt"}, 256'(layer_cnt), 256'(exp_cnt));
      check({tag, "/buf_sel"}, 256'(buf_sel), 256'(exp_cnt % 2));
      check({tag, "/err"}, 256'(err), 256'(exp_err));
      check({tag, "/one_done"}, 256'(done_cnt), 256'(d0 + 1));
      check({tag, "/busy_low"}, 256'(busy), 256'(0));
   endtask

   task automatic applyStimulus(input logic [7:0] base, input int clat, input int mlat,
                                input int busy_start_at, input bit check_ra, input string tag);
      int d0;
      conv_lat = clat;
      maxp_lat = mlat;
      build_expected(base);
      launch_kind.delete();
      launch_geo.delete();
      launch_bs.delete();
      d0 = done_cnt;
      base_addr = base;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check({tag, "/busy_high"}, 256'(busy), 256'(1));
      if (check_ra) begin
         for (int kk = 0; kk < 8; kk++) begin
            check({tag, "/cfg_ra"}, 256'(cfg_ra), 256'(8'(base + 8'(kk))));
            tick(1);
         end
      end
      if (busy_start_at > 0) begin
         tick(busy_start_at);
         base_addr = 8'h80;
         start = 1'b1;
         tick(1);
         start = 1'b0;
         base_addr = base;
      end
      wait_done(d0, tag);
      compare_run(d0, tag);
   endtask

   task automatic checkOutput(input string tag);
      check({tag, "/all_zero"},
            256'({cfg_ra, R, C, M, nIR, nIC, nP, MP, conv_en, maxp_en, buf_sel,
                  layer_cnt, busy, done, err}), 256'(0));
   endtask

   initial begin
      int d0;
      int nsz;
      logic [7:0]  b;
      logic [31:0] t;
      int nl;

      rst = 1'b1;
      start = 1'b0;
      base_addr = 8'h00;
      conv_man = 1'b0;
      maxp_man = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      tick(3);
      checkOutput("reset");
      rst = 1'b0;
      tick(2);

      // Two-layer run with a stray start issued while the conv engine is busy.
      write_desc(8'h00, 32'd1, 32'd28, 32'd28, 32'd6, 32'd32, 32'd32, 32'd1, 32'd0);
      write_desc(8'h08, 32'd2, 32'd14, 32'd14, 32'd6, 32'd28, 32'd28, 32'd2, 32'd2);
      rom[8'h10] = 32'd0;
      rom[8'h80] = 32'd7;
      applyStimulus(8'h00, 50, 30, 25, 1'b0, "two_layer");

      // Spurious maxp_done during a conv wait.
      write_desc(8'h40, 32'd1, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17);
      rom[8'h48] = 32'd0;
      auto_resp = 1'b0;
      build_expected(8'h40);
      launch_kind.delete();
      launch_geo.delete();
      launch_bs.delete();
      d0 = done_cnt;
      base_addr = 8'h40;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      for (int i = 0; i < 40 && launch_kind.size() == 0; i++) tick(1);
      check("spur/launched", 256'(launch_kind.size()), 256'(1));
      tick(5);
      maxp_man = 1'b1;
      tick(1);
      maxp_man = 1'b0;
      tick(3);
      check("spur/busy", 256'(busy), 256'(1));
      check("spur/buf_hold", 256'(buf_sel), 256'(0));
      check("spur/cnt_hold", 256'(layer_cnt), 256'(0));
      conv_man = 1'b1;
      tick(1);
      conv_man = 1'b0;
      check("spur/buf_toggle", 256'(buf_sel), 256'(1));
      check("spur/cnt_inc", 256'(layer_cnt), 256'(1));
      wait_done(d0, "spur");
      compare_run(d0, "spur");
      auto_resp = 1'b1;

      // Illegal descriptor type.
      rom[8'h20] = 32'd7;
      applyStimulus(8'h20, 5, 5, 0, 1'b0, "illegal");

      // Address wrap across the top of the ROM.
      write_desc(8'hFC, 32'd1, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7);
      rom[8'h04] = 32'd0;
      applyStimulus(8'hFC, 7, 7, 0, 1'b1, "wrap");

      // One more MAXP descriptor than the run limit, with no terminator.
      for (int i = 0; i < 17; i++)
         write_desc(8'(8'h10 + 8'(8 * i)), 32'd2, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom);
      applyStimulus(8'h10, 3, 3, 0, 1'b0, "overlen");

      // Randomized descriptor chains.
      for (int r = 0; r < 4; r++) begin
         b = 8'($urandom);
         nl = $urandom_range(1, 5);
         for (int i = 0; i < nl; i++) begin
            t = 32'($urandom_range(1, 2));
            if (i == nl - 1 && $urandom_range(0, 2) == 0) t = 32'($urandom_range(3, 12));
            write_desc(8'(b + 8'(8 * i)), t, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom);
         end
         rom[8'(b + 8'(8 * nl))] = 32'd0;
         applyStimulus(b, $urandom_range(1, 40), $urandom_range(1, 40), 0, 1'b0, "rand");
      end

      // Reset in the middle of the second layer's wait.
      write_desc(8'h30, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7);
      write_desc(8'h38, 32'd1, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9);
      rom[8'h40] = 32'd0;
      conv_lat = 40;
      launch_kind.delete();
      launch_geo.delete();
      launch_bs.delete();
      d0 = done_cnt;
      base_addr = 8'h30;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      for (int i = 0; i < 200 && launch_kind.size() < 2; i++) tick(1);
      check("midrst/second_launch", 256'(launch_kind.size()), 256'(2));
      tick(5);
      check("midrst/buf_before", 256'(buf_sel), 256'(1));
      rst = 1'b1;
      #1;
      checkOutput("midrst_async");
      tick(2);
      rst = 1'b0;
      nsz = launch_kind.size();
      tick(100);
      checkOutput("midrst_after");
      check("midrst/no_en", 256'(launch_kind.size()), 256'(nsz));
      check("midrst/no_done", 256'(done_cnt), 256'(d0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/layer_seq.md
Name: layer_seq

Overview:
- Top-level layer scheduler for the CNN accelerator. It walks a descriptor list in config ROM and loads each layer's geometry into shared config registers.
- It starts the conv or maxp engine with a one-cycle en pulse, waits for that engine's done, then flips the ping-pong feature-buffer select.
- It sits between the host start/done interface and the conv/maxp engines. It owns the R/C/M/nIR/nIC/nP/MP buses for both engines.

Parameters:
- DATA_SIZE, 32, width of descriptor words and config buses
- CFG_ADDR_BITS, 8, config ROM address width
- MAX_LAYERS, 16, maximum descriptors processed per run before forced error stop
- LAYER_BITS, 5, width of layer counter (must hold MAX_LAYERS)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle run request; ignored unless in IDLE
- base_addr  in  CFG_ADDR_BITS  ROM address of first descriptor; sampled on accepted start
- cfg_ra  out  CFG_ADDR_BITS  config ROM read address
- cfg_rd  in  DATA_SIZE  config ROM read data, valid 1 cycle after cfg_ra
- R, C, M, nIR, nIC, nP, MP  out  DATA_SIZE each  registered layer geometry, shared by both engines
- conv_en  out  1  one-cycle start pulse to conv engine
- conv_done  in  1  one-cycle completion pulse from conv engine
- maxp_en  out  1  one-cycle start pulse to maxp engine
- maxp_done  in  1  one-cycle completion pulse from maxp engine
- buf_sel  out  1  ping-pong select: 0 = engine reads bank A and writes bank B; 1 = the reverse
- layer_cnt  out  LAYER_BITS  layers completed in the current run
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- err  out  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Reset: state=IDLE. All outputs 0: cfg_ra, config regs, conv_en, maxp_en, buf_sel, layer_cnt, busy, done, err. Reset mid-run aborts immediately; no en pulse is issued afterwards.
- Descriptor format: 8 consecutive words. Word 0 = type (0 = END, 1 = CONV, 2 = MAXP, other values = illegal). Words 1..7 = R, C, M, nIR, nIC, nP, MP.
- IDLE: on start, set ptr=base_addr, layer_cnt=0, err=0, buf_sel=0. Go to FETCH.
- FETCH: 8 cycles with k=0..7, cfg_ra=ptr+k. cfg_rd is captured one cycle later into word k. The k=7 capture happens in the first cycle of DECODE. Address arithmetic wraps modulo 2^CFG_ADDR_BITS.
- Config regs are updated only during FETCH captures. Words 1..7 are written directly. The type word goes to an internal register only.
- DECODE (1 cycle, after the last capture):
  - type=0: go to FIN.
  - type=1 or 2: go to LAUNCH.
  - illegal type: set err, go to FIN.
  - layer_cnt==MAX_LAYERS before launch: set err, go to FIN.
- LAUNCH (1 cycle): assert conv_en or maxp_en for exactly one cycle per type. Go to WAIT.
- WAIT:
  - Wait for the done of the launched engine only; the other engine's done is ignored.
  - On done: toggle buf_sel, layer_cnt+=1, ptr+=8, go to FETCH.
  - The next FETCH starts the cycle after done.
  - No timeout.
- FIN (1 cycle): done=1, busy=0 next cycle, go to IDLE. buf_sel and layer_cnt hold their values until the next start.
- start while busy: ignored, no side effect.
- done input asserted in the same cycle as LAUNCH: ignored. Engines cannot complete in 0 cycles.
- Config registers stay stable from LAUNCH through the engine's done. Minimum latency from done to the next en pulse is 10 cycles (8 FETCH + DECODE + LAUNCH).

Test Plan:
- Two-layer run. ROM@0: CONV{R=28,C=28,M=6,nIR=32,nIC=32,nP=1,MP=0}, MAXP{R=14,C=14,M=6,nIR=28,nIC=28,nP=2,MP=2}, END. Pulse start with base=0; conv_done 50 cycles after conv_en; maxp_done 30 cycles after maxp_en. Required: conv_en then maxp_en with regs matching each descriptor at en; buf_sel 0→1→0; layer_cnt=2; one done pulse; err=0.
- Spurious done: during conv WAIT, pulse maxp_done → no state change. Then conv_done → buf_sel toggles once.
- Illegal type: descriptor word 0=7 → no en pulse, err=1, done pulse, layer_cnt=0.
- Wrap-around: base=0xFC, CONV then END spanning 0xFC..0x0B → cfg_ra sequence wraps 0xFF→0x00; conv regs loaded correctly.
- Over-length: MAX_LAYERS+1 MAXP descriptors with no END → exactly MAX_LAYERS maxp_en pulses, then err=1 and done.
- Reset mid-WAIT, plus start while busy → after rst all outputs 0, state IDLE, no en pulse. A start pulsed during a run has no effect on ptr, err or buf_sel.
